bludge_manager: RTL and testbench

//   Bludger-hit detector for one vertical player. Compares the bludger position

---
 rtl/bludge_if.sv | 37 +++
 rtl/bludge_manager.sv | 149 ++++++++++++++
 tb/tb_bludge_manager.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bludge_if.sv
// Signal bundle between the bludger ball logic, the vertical player controller
// and the bludger-hit detector.
interface bludge_if;
   logic [9:0] ver_pos;
   logic [9:0] bludger_x;
   logic [9:0] bludger_y;
   logic       bludger_active;
   logic       clean_bludge;
   logic       bludged;
   logic       hit_pulse;
   logic       immune;
   logic [3:0] hit_count;

   modport master (
      output ver_pos,
      output bludger_x,
      output bludger_y,
      output bludger_active,
      output clean_bludge,
      input  bludged,
      input  hit_pulse,
      input  immune,
      input  hit_count
   );

   modport slave (
      input  ver_pos,
      input  bludger_x,
      input  bludger_y,
      input  bludger_active,
      input  clean_bludge,
      output bludged,
      output hit_pulse,
      output immune,
      output hit_count
   );
endinterface

// File: rtl/bludge_manager.sv
// Bludger-hit detector for one vertical player: circle-overlap test, hit
// confirmation, stun hand-off to the player controller and post-stun immunity.
module bludge_manager #(
   parameter int PLAYER_RADIUS   = 25,
   parameter int BALL_RADIUS     = 10,
   parameter int HOR_POS         = 100,
   parameter int HIT_CONFIRM     = 2,
   parameter int IMMUNITY_CYCLES = 50000000
) (
   input logic     clk,
   input logic     reset,
   bludge_if.slave bus
);

   // The confirm counter only ever holds 0..HIT_CONFIRM-1; reaching HIT_CONFIRM is the hit itself.
   localparam int CONF_W = (HIT_CONFIRM > 1) ? $clog2(HIT_CONFIRM) : 1;
   localparam int TMR_W  = (IMMUNITY_CYCLES > 1) ? $clog2(IMMUNITY_CYCLES) : 1;

   localparam logic [9:0]        HOR        = 10'(HOR_POS);
   localparam logic [20:0]       HIT_THRESH = 21'((PLAYER_RADIUS + BALL_RADIUS) *
                                                  (PLAYER_RADIUS + BALL_RADIUS));
   localparam logic [CONF_W-1:0] CONF_LAST  = CONF_W'(HIT_CONFIRM - 1);
   localparam logic [CONF_W-1:0] CONF_ONE   = CONF_W'(1);
   localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(IMMUNITY_CYCLES - 1);
   localparam logic [TMR_W-1:0]  TMR_ONE    = TMR_W'(1);

   typedef enum logic [1:0] {
      ARMED   = 2'd0,
      STUNNED = 2'd1,
      IMMUNE  = 2'd2
   } state_t;

   function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   function automatic logic [19:0] square10(input logic [9:0] v);
      return {10'd0, v} * {10'd0, v};
   endfunction

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : (v + 4'd1);
   endfunction

   logic [9:0]  dx;
   logic [9:0]  dy;
   logic [19:0] dx_sq;
   logic [19:0] dy_sq;
   logic [20:0] dist_sq;
   logic        overlap;
   logic        overlap_q;
   logic        hit_sample;

   state_t            state;
   state_t            state_n;
   logic [CONF_W-1:0] confirm_cnt;
   logic [CONF_W-1:0] confirm_n;
   logic [TMR_W-1:0]  timer;
   logic [TMR_W-1:0]  timer_n;
   logic              hit_pulse_r;
   logic              pulse_n;
   logic [3:0]        hit_count_r;
   logic [3:0]        count_n;

   // Unsigned distances; coordinates are taken as plain 10-bit values, no wrap handling.
   always_comb begin
      dx      = abs_diff(HOR, bus.bludger_x);
      dy      = abs_diff(bus.ver_pos, bus.bludger_y);
      dx_sq   = square10(dx);
      dy_sq   = square10(dy);
      dist_sq = {1'b0, dx_sq} + {1'b0, dy_sq};
      overlap = (dist_sq < HIT_THRESH);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overlap_q <= 1'b0;
      end else begin
         overlap_q <= overlap;
      end
   end

   assign hit_sample = overlap_q & bus.bludger_active;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ARMED;
         confirm_cnt <= '0;
         timer       <= '0;
         hit_pulse_r <= 1'b0;
         hit_count_r <= 4'd0;
      end else begin
         state       <= state_n;
         confirm_cnt <= confirm_n;
         timer       <= timer_n;
         hit_pulse_r <= pulse_n;
         hit_count_r <= count_n;
      end
   end

   always_comb begin
      state_n   = state;
      confirm_n = confirm_cnt;
      timer_n   = timer;
      pulse_n   = 1'b0;
      count_n   = hit_count_r;
      case (state)
         ARMED: begin
            if (hit_sample) begin
               if (confirm_cnt == CONF_LAST) begin
                  state_n   = STUNNED;
                  confirm_n = '0;
                  pulse_n   = 1'b1;
                  count_n   = sat_inc4(hit_count_r);
               end else begin
                  confirm_n = confirm_cnt + CONF_ONE;
               end
            end else begin
               confirm_n = '0;
            end
         end
         STUNNED: begin
            // Overlap is irrelevant here; only the controller's release matters.
            if (bus.clean_bludge) begin
               state_n = IMMUNE;
               timer_n = TMR_LOAD;
            end
         end
         IMMUNE: begin
            if (timer == '0) begin
               state_n   = ARMED;
               confirm_n = '0;
            end else begin
               timer_n = timer - TMR_ONE;
            end
         end
         default: begin
            state_n   = ARMED;
            confirm_n = '0;
         end
      endcase
   end

   assign bus.bludged   = (state == STUNNED);
   assign bus.immune    = (state == IMMUNE);
   assign bus.hit_pulse = hit_pulse_r;
   assign bus.hit_count = hit_count_r;

endmodule

// File: tb/tb_bludge_manager.sv
// Self-checking bench for bludge_manager: vector table of overlap geometries
// plus hand-written sequences for confirm, stun, immunity, saturation and reset.
module tb_bludge_manager;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   bludge_if bus();

   bludge_manager #(
      .PLAYER_RADIUS  (25),
      .BALL_RADIUS    (10),
      .HOR_POS        (100),
      .HIT_CONFIRM    (2),
      .IMMUNITY_CYCLES(20)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [9:0] ver_pos;
      logic [9:0] bx;
      logic [9:0] by;
      logic       act;
      int         exp_hit;
   } vec_t;

   typedef struct {
      string name;
      int    value;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input string name, input int value);
      exp_t e;
      e.name  = name;
      e.value = value;
      sb.push_back(e);
   endtask

   task automatic pop_check(input int actual);
      exp_t e;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         check(e.name, actual, e.value);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [9:0] v, input logic [9:0] bx, input logic [9:0] by,
                        input logic act);
      bus.ver_pos        = v;
      bus.bludger_x      = bx;
      bus.bludger_y      = by;
      bus.bludger_active = act;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   vec_t vecs[12];
   int   imm_cycles;
   int   ok;
   int   seen;

   initial begin
      vecs[0]  = '{"v_dy30",        10'd200, 10'd100, 10'd170, 1'b1, 1};
      vecs[1]  = '{"v_dy35_edge",   10'd200, 10'd100, 10'd165, 1'b1, 0};
      vecs[2]  = '{"v_centre",      10'd200, 10'd100, 10'd200, 1'b1, 1};
      vecs[3]  = '{"v_21_28_edge",  10'd200, 10'd121, 10'd228, 1'b1, 0};
      vecs[4]  = '{"v_20_28",       10'd200, 10'd120, 10'd172, 1'b1, 1};
      vecs[5]  = '{"v_dx34",        10'd200, 10'd134, 10'd200, 1'b1, 1};
      vecs[6]  = '{"v_dx35_edge",   10'd200, 10'd65,  10'd200, 1'b1, 0};
      vecs[7]  = '{"v_far",         10'd200, 10'd300, 10'd300, 1'b1, 0};
      vecs[8]  = '{"v_no_wrap",     10'd5,   10'd100, 10'd1020, 1'b1, 0};
      vecs[9]  = '{"v_inactive",    10'd200, 10'd100, 10'd200, 1'b0, 0};
      vecs[10] = '{"v_top_edge",    10'd0,   10'd100, 10'd34,  1'b1, 1};
      vecs[11] = '{"v_x_zero",      10'd500, 10'd0,   10'd500, 1'b1, 0};

      reset = 1'b1;
      bus.clean_bludge = 1'b0;
      drive(10'd0, 10'd0, 10'd0, 1'b0);
      tick(2);
      check("rst_bludged",   bus.bludged,   0);
      check("rst_hit_pulse", bus.hit_pulse, 0);
      check("rst_immune",    bus.immune,    0);
      check("rst_hit_count", bus.hit_count, 0);
      reset = 1'b0;

      // Vector table: hold each geometry for HIT_CONFIRM+1 edges from a fresh reset.
      for (int i = 0; i < 12; i++) begin
         do_reset();
         drive(vecs[i].ver_pos, vecs[i].bx, vecs[i].by, vecs[i].act);
         push_exp({vecs[i].name, "_bludged"}, vecs[i].exp_hit);
         tick(3);
         pop_check(bus.bludged);
         check({vecs[i].name, "_pulse"}, bus.hit_pulse, vecs[i].exp_hit);
      end

      // Hit latency and single-cycle pulse.
      do_reset();
      drive(10'd200, 10'd100, 10'd170, 1'b1);
      tick();
      check("t1_edge1_bludged", bus.bludged, 0);
      tick();
      check("t1_edge2_bludged", bus.bludged, 0);
      tick();
      check("t1_edge3_bludged", bus.bludged, 1);
      check("t1_edge3_pulse",   bus.hit_pulse, 1);
      tick();
      check("t1_edge4_pulse",   bus.hit_pulse, 0);
      check("t1_edge4_bludged", bus.bludged, 1);
      check("t1_hit_count",     bus.hit_count, 1);

      // Exactly on the threshold never hits.
      do_reset();
      drive(10'd200, 10'd100, 10'd165, 1'b1);
      seen = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (bus.bludged) seen = 1;
      end
      check("t2_threshold_no_hit", seen, 0);

      // One overlap sample then away: no hit and the counter restarts from zero.
      do_reset();
      drive(10'd200, 10'd100, 10'd170, 1'b1);
      tick();
      drive(10'd200, 10'd300, 10'd300, 1'b1);
      tick(5);
      check("t3_no_hit", bus.bludged, 0);
      drive(10'd200, 10'd100, 10'd170, 1'b1);
      tick(2);
      check("t3_reapply_early", bus.bludged, 0);
      tick();
      check("t3_reapply_hit", bus.bludged, 1);

      // bludger_active dropping mid-count clears the counter.
      do_reset();
      drive(10'd200, 10'd100, 10'd170, 1'b1);
      tick(2);
      bus.bludger_active = 1'b0;
      tick();
      check("t3b_inactive", bus.bludged, 0);
      bus.bludger_active = 1'b1;
      tick();
      check("t3b_recount", bus.bludged, 0);
      tick();
      check("t3b_hit", bus.bludged, 1);

      // Stun hold, release, immunity length and re-arm with persistent overlap.
      do_reset();
      drive(10'd200, 10'd100, 10'd170, 1'b1);
      tick(3);
      tick(10);
      check("t4_stun_held", bus.bludged, 1);
      bus.clean_bludge = 1'b1;
      tick();
      bus.clean_bludge = 1'b0;
      check("t4_release_bludged", bus.bludged, 0);
      check("t4_release_immune",  bus.immune, 1);
      imm_cycles = 1;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (bus.bludged) seen = 1;
         if (bus.immune) imm_cycles++;
         else break;
      end
      check("t4_immune_cycles", imm_cycles, 20);
      check("t4_no_hit_immune", seen, 0);
      tick();
      check("t4_rearm_edge1", bus.bludged, 0);
      tick();
      check("t4_rearm_edge2", bus.bludged, 1);

      // Repeated hits: hit_count saturates at 15.
      do_reset();
      drive(10'd200, 10'd100, 10'd170, 1'b1);
      for (int k = 1; k <= 17; k++) begin
         push_exp($sformatf("t5_hit_count_%0d", k), (k > 15) ? 15 : k);
         ok = 0;
         for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.hit_pulse) begin
               ok = 1;
               break;
            end
         end
         if (ok == 0) begin
            check($sformatf("t5_hit_timeout_%0d", k), 0, 1);
            void'(sb.pop_front());
         end else begin
            pop_check(bus.hit_count);
         end
         bus.clean_bludge = 1'b1;
         tick();
         bus.clean_bludge = 1'b0;
         ok = 0;
         for (int c = 0; c < 30; c++) begin
            tick();
            if (!bus.immune) begin
               ok = 1;
               break;
            end
         end
         if (ok == 0) check($sformatf("t5_immune_timeout_%0d", k), 0, 1);
      end
      check("t5_saturated", bus.hit_count, 15);

      // Asynchronous reset between edges while stunned.
      do_reset();
      drive(10'd200, 10'd100, 10'd170, 1'b1);
      tick(3);
      check("t6_pre_bludged", bus.bludged, 1);
      #3;
      reset = 1'b1;
      #1;
      check("t6_async_bludged",   bus.bludged,   0);
      check("t6_async_pulse",     bus.hit_pulse, 0);
      check("t6_async_hit_count", bus.hit_count, 0);
      check("t6_async_immune",    bus.immune,    0);
      @(negedge clk);
      reset = 1'b0;
      drive(10'd200, 10'd300, 10'd300, 1'b1);
      bus.clean_bludge = 1'b1;
      tick(5);
      check("t6_armed_bludged", bus.bludged, 0);
      check("t6_armed_immune",  bus.immune,  0);
      bus.clean_bludge = 1'b0;

      if (sb.size() != 0) check("scoreboard_leftover", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
